// File: rtl/sub64bit_seq.sv
// sub64bit_seq -- chunk-serial 64-bit two's-complement subtractor.
//
// Computes diff = A - B as A + ~B + 1, CHUNK bits per clock, LSB chunk first,
// and produces the Y86-64 condition codes (ZF, SF, OF) for subq / compare.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     request; sampled only while idle
//   A, B      minuend / subtrahend, latched when start is accepted
//   busy      high while an operation is running or finishing
//   done      one-cycle pulse; results below are valid from this cycle on
//   diff      A - B modulo 2^64 (registered, holds until the next done)
//   overflow  signed overflow of the subtraction
//   zf        diff == 0
//   sf        diff[63]
module sub64bit_seq #(
   parameter int CHUNK = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [63:0] A,
   input  logic [63:0] B,
   output logic        busy,
   output logic        done,
   output logic [63:0] diff,
   output logic        overflow,
   output logic        zf,
   output logic        sf
);

   localparam int         N    = 64 / CHUNK;
   localparam logic [6:0] LAST = 7'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_reg, state_next;
   logic [6:0]         cnt_reg;
   logic               carry_reg;
   logic [63:0]        a_reg, b_reg, res_reg;
   logic [63:0]        res_full;
   logic [CHUNK-1:0]   a_chunk, b_chunk, sum_chunk;
   logic               carry_out;
   logic               accept, last;

   assign accept = (state_reg == IDLE) && start;
   assign last   = (state_reg == RUN) && (cnt_reg == LAST);

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      busy       = 1'b0;
      done       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) state_next = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (cnt_reg == LAST) state_next = DONE;
         end
         DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Chunk datapath
   // ------------------------------------------------------------------
   // Operand chunk selected by the counter (constant-index mux).
   always_comb begin
      a_chunk = '0;
      b_chunk = '0;
      for (int k = 0; k < N; k++) begin
         if (cnt_reg == 7'(k)) begin
            a_chunk = a_reg[k*CHUNK +: CHUNK];
            b_chunk = b_reg[k*CHUNK +: CHUNK];
         end
      end
   end

   // Inverted subtrahend plus carry; carry_reg starts at 1 to supply the +1.
   assign {carry_out, sum_chunk} = {1'b0, a_chunk} + {1'b0, ~b_chunk}
                                 + {{CHUNK{1'b0}}, carry_reg};

   // Result with the current chunk merged in. On the last RUN cycle this is
   // the complete difference, so the outputs load from it in one step.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_merge
         assign res_full[gi*CHUNK +: CHUNK] =
            (cnt_reg == 7'(gi)) ? sum_chunk : res_reg[gi*CHUNK +: CHUNK];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg     <= '0;
         b_reg     <= '0;
         res_reg   <= '0;
         cnt_reg   <= '0;
         carry_reg <= 1'b0;
      end else if (accept) begin
         a_reg     <= A;
         b_reg     <= B;
         res_reg   <= '0;
         cnt_reg   <= '0;
         carry_reg <= 1'b1;
      end else if (state_reg == RUN) begin
         res_reg   <= res_full;
         carry_reg <= carry_out;
         cnt_reg   <= cnt_reg + 7'd1;
      end
   end

   // ------------------------------------------------------------------
   // Result and flag registers: updated only when the full result exists.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         diff     <= '0;
         overflow <= 1'b0;
         zf       <= 1'b0;
         sf       <= 1'b0;
      end else if (last) begin
         diff     <= res_full;
         overflow <= (a_reg[63] != b_reg[63]) && (res_full[63] != a_reg[63]);
         zf       <= (res_full == 64'd0);
         sf       <= res_full[63];
      end
   end

endmodule

// File: tb/tb_sub64bit_seq.sv
// tb_sub64bit_seq -- drives three sub64bit_seq instances (CHUNK = 8, 1, 64)
// in lockstep from shared inputs and compares each against a wide-integer
// reference of A - B and its condition codes.
module tb_sub64bit_seq;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [63:0] A     = '0;
   logic [63:0] B     = '0;

   logic [2:0]  busy_w, done_w, of_w, zf_w, sf_w;
   logic [63:0] diff_w [3];

   int vectors = 0;
   int errors  = 0;
   int cyc     = 0;

   logic [63:0] hold_diff  [3];
   logic [2:0]  hold_flags [3];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_dut
         localparam int CW = (gi == 0) ? 8 : ((gi == 1) ? 1 : 64);
         sub64bit_seq #(.CHUNK(CW)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .start    (start),
            .A        (A),
            .B        (B),
            .busy     (busy_w[gi]),
            .done     (done_w[gi]),
            .diff     (diff_w[gi]),
            .overflow (of_w[gi]),
            .zf       (zf_w[gi]),
            .sf       (sf_w[gi])
         );
      end
   endgenerate

   function automatic int chunk_of(input int i);
      case (i)
         0:       return 8;
         1:       return 1;
         default: return 64;
      endcase
   endfunction

   // Reference: exact 65-bit signed difference; overflow means the true
   // result does not fit in 64 signed bits. Flags packed {of, zf, sf}.
   function automatic void model(input logic [63:0] a, input logic [63:0] b,
                                 output logic [63:0] d, output logic [2:0] f);
      logic signed [64:0] w;
      w = $signed({a[63], a}) - $signed({b[63], b});
      d = w[63:0];
      f = {w[64] != w[63], d == 64'd0, d[63]};
   endfunction

   task automatic check_value(input string tag, input logic [63:0] got,
                              input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_reset_outputs(input string where);
      for (int i = 0; i < 3; i++) begin
         check_value($sformatf("%s_c%0d_busy", where, chunk_of(i)), 64'(busy_w[i]), 64'd0);
         check_value($sformatf("%s_c%0d_done", where, chunk_of(i)), 64'(done_w[i]), 64'd0);
         check_value($sformatf("%s_c%0d_diff", where, chunk_of(i)), diff_w[i], 64'd0);
         check_value($sformatf("%s_c%0d_flags", where, chunk_of(i)),
                     64'({of_w[i], zf_w[i], sf_w[i]}), 64'd0);
      end
   endtask

   // One transaction: start held for 'hold' edges; with 'extra', a second
   // request (A=5, B=3) is presented two edges after acceptance and must be
   // ignored. Operands are scrambled after acceptance.
   task automatic run_op(input logic [63:0] a, input logic [63:0] b,
                         input int hold, input bit extra);
      logic [63:0] ed;
      logic [2:0]  ef;
      int          t0, rel, n, p;
      int          next_done [3];
      int          dcount    [3];
      int          accepts   [3];
      logic        exp_busy;
      model(a, b, ed, ef);
      for (int i = 0; i < 3; i++) begin
         n            = 64 / chunk_of(i);
         p            = n + 2;
         next_done[i] = n;
         dcount[i]    = 0;
         accepts[i]   = (hold + p - 1) / p;
      end
      @(negedge clk);
      A     = a;
      B     = b;
      start = 1'b1;
      t0    = cyc + 1;
      for (int c = 0; c < hold + 72; c++) begin
         @(negedge clk);
         rel = cyc - t0;
         if (rel == hold - 1) begin
            start = 1'b0;
            A     = {$urandom, $urandom};
            B     = {$urandom, $urandom};
         end
         if (extra && rel == 1) begin
            start = 1'b1;
            A     = 64'd5;
            B     = 64'd3;
         end
         if (extra && rel == 2) begin
            start = 1'b0;
            A     = {$urandom, $urandom};
            B     = {$urandom, $urandom};
         end
         for (int i = 0; i < 3; i++) begin
            n        = 64 / chunk_of(i);
            p        = n + 2;
            exp_busy = ((rel / p) < accepts[i]) && ((rel % p) <= n);
            check_value($sformatf("c%0d_busy_rel%0d", chunk_of(i), rel),
                        64'(busy_w[i]), 64'(exp_busy));
            if (done_w[i]) begin
               check_value($sformatf("c%0d_done_latency", chunk_of(i)),
                           64'(rel), 64'(next_done[i]));
               check_value($sformatf("c%0d_diff", chunk_of(i)), diff_w[i], ed);
               check_value($sformatf("c%0d_flags_ozs", chunk_of(i)),
                           64'({of_w[i], zf_w[i], sf_w[i]}), 64'(ef));
               hold_diff[i]  = ed;
               hold_flags[i] = ef;
               dcount[i]++;
               next_done[i] += p;
            end else begin
               check_value($sformatf("c%0d_hold_diff", chunk_of(i)),
                           diff_w[i], hold_diff[i]);
               check_value($sformatf("c%0d_hold_flags", chunk_of(i)),
                           64'({of_w[i], zf_w[i], sf_w[i]}), 64'(hold_flags[i]));
            end
         end
      end
      for (int i = 0; i < 3; i++) begin
         check_value($sformatf("c%0d_done_count", chunk_of(i)),
                     64'(dcount[i]), 64'(accepts[i]));
      end
      $display("op A=%h B=%h hold=%0d extra=%0d -> diff=%h ozs=%b",
               a, b, hold, extra, ed, ef);
   endtask

   initial begin
      logic [63:0] ra, rb;
      for (int i = 0; i < 3; i++) begin
         hold_diff[i]  = '0;
         hold_flags[i] = '0;
      end

      // Power-on reset
      #12;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Directed vectors
      run_op(64'd620, -64'sd34, 1, 1'b0);
      run_op(64'd0, 64'd1, 1, 1'b0);
      run_op(64'h8000_0000_0000_0000, 64'd1, 1, 1'b0);
      run_op(64'h7FFF_FFFF_FFFF_FFFF, -64'sd1, 1, 1'b0);
      run_op(64'd9871486, 64'd9871486, 1, 1'b0);
      run_op(-64'sd78928, 64'd9871486, 1, 1'b1);

      // start held high: back-to-back operations
      run_op({$urandom, $urandom}, {$urandom, $urandom}, 30, 1'b0);

      // Randomized vectors with a bias toward flag corner cases
      for (int k = 0; k < 10; k++) begin
         ra = {$urandom, $urandom};
         case ($urandom_range(0, 3))
            0:       rb = {$urandom, $urandom};
            1:       rb = ra;
            2:       rb = ra ^ 64'h8000_0000_0000_0000;
            default: begin
               ra[63] = 1'b1;
               rb     = {1'b0, 31'($urandom), $urandom};
            end
         endcase
         run_op(ra, rb, 1, 1'b0);
      end

      // Reset in the middle of an operation
      @(negedge clk);
      A     = 64'd123456789;
      B     = 64'd987;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrun_reset");
      for (int i = 0; i < 3; i++) begin
         hold_diff[i]  = '0;
         hold_flags[i] = '0;
      end
      @(negedge clk);
      check_reset_outputs("reset_held");
      rst_n = 1'b1;
      $display("op mid-run reset applied and released");
      run_op(64'd10, 64'd4, 1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
